// File: rtl/spi_cmd_decoder_if.sv
// Cartridge-side memory request bus between spi_cmd_decoder (master) and memory (slave).
// One single-byte request at a time, held until a one-cycle mem_ack.
interface spi_cmd_decoder_if #(
    parameter int ADDR_W = 24
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: parses opcode + 24-bit address + data frames into memory requests.
// Define SPI_CMD_AUTOINC_EN for burst address increment; otherwise the address is fixed per frame.
module spi_cmd_decoder #(
    parameter int         ADDR_W    = 24,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_busy,
    input  logic [7:0]        spi_in_byte,
    output logic [7:0]        spi_out_byte,
    spi_cmd_decoder_if.master mem
);
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h05;
`ifdef SPI_CMD_AUTOINC_EN
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_A2, ST_A1, ST_A0, ST_RD, ST_WR, ST_STAT, ST_DROP
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [7:0]        out_q, out_d;
    logic              ovr_q, ovr_d;
    logic [7:0]        pf_q, pf_d;
    logic              pf_valid_q, pf_valid_d;
    logic              is_wr_q, is_wr_d;
    logic              byte_done;

    assign byte_done = busy_q & ~spi_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (spi_cs_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        case (spi_in_byte)
                            OP_READ, OP_WRITE: state_d = ST_A2;
                            OP_STATUS:         state_d = ST_STAT;
                            default:           state_d = ST_DROP;
                        endcase
                    end
                end
                ST_A2: if (byte_done) state_d = ST_A1;
                ST_A1: if (byte_done) state_d = ST_A0;
                ST_A0: if (byte_done) state_d = is_wr_q ? ST_WR : ST_RD;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy_d     = spi_busy;
        addr_d     = addr_q;
        req_addr_d = req_addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        re_d       = re_q;
        out_d      = out_q;
        ovr_d      = ovr_q;
        pf_d       = pf_q;
        pf_valid_d = pf_valid_q;
        is_wr_d    = is_wr_q;

        // The acknowledge is retired before this cycle's byte is looked at, so a
        // same-cycle ack feeds the prefetch and frees the bus for the next request.
        if (mem.mem_ack) begin
            if (we_q) addr_d = addr_q + ADDR_STEP;
            if (re_q && state_q == ST_RD) begin
                pf_d       = mem.mem_rdata;
                pf_valid_d = 1'b1;
            end
            we_d = 1'b0;
            re_d = 1'b0;
        end

        if (spi_cs_n) begin
            out_d      = IDLE_BYTE;
            pf_valid_d = 1'b0;
        end else if (byte_done) begin
            case (state_q)
                ST_CMD: begin
                    is_wr_d = (spi_in_byte == OP_WRITE);
                    if (spi_in_byte == OP_STATUS) out_d = {6'b0, ovr_q, we_d | re_d};
                end
                ST_A2, ST_A1: addr_d = {addr_q[ADDR_W-9:0], spi_in_byte};
                ST_A0: begin
                    addr_d = {addr_q[ADDR_W-9:0], spi_in_byte};
                    if (!is_wr_q) begin
                        // A request left over from an aborted frame still owns the bus.
                        if (we_d | re_d) begin
                            ovr_d = 1'b1;
                        end else begin
                            re_d       = 1'b1;
                            req_addr_d = addr_d;
                            pf_valid_d = 1'b0;
                        end
                    end
                end
                ST_RD: begin
                    if (pf_valid_d) begin
                        out_d      = pf_d;
                        pf_valid_d = 1'b0;
                        addr_d     = addr_q + ADDR_STEP;
                        req_addr_d = addr_d;
                        re_d       = 1'b1;
                    end else begin
                        out_d = IDLE_BYTE;
                        ovr_d = 1'b1;
                    end
                end
                ST_WR: begin
                    if (we_d | re_d) begin
                        ovr_d = 1'b1;
                    end else begin
                        we_d       = 1'b1;
                        wdata_d    = spi_in_byte;
                        req_addr_d = addr_d;
                    end
                end
                ST_STAT: begin
                    ovr_d = 1'b0;
                    out_d = IDLE_BYTE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            addr_q     <= '0;
            req_addr_q <= '0;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            out_q      <= IDLE_BYTE;
            ovr_q      <= 1'b0;
            pf_q       <= 8'h00;
            pf_valid_q <= 1'b0;
            is_wr_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            req_addr_q <= req_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            out_q      <= out_d;
            ovr_q      <= ovr_d;
            pf_q       <= pf_d;
            pf_valid_q <= pf_valid_d;
            is_wr_q    <= is_wr_d;
        end
    end

    assign spi_out_byte  = out_q;
    assign mem.mem_addr  = req_addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_re    = re_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed and random frames against a
// byte-addressed memory model with randomized acknowledge latency.
module tb_spi_cmd_decoder;
`ifdef SPI_CMD_AUTOINC_EN
    localparam logic [23:0] STEP = 24'd1;
`else
    localparam logic [23:0] STEP = 24'd0;
`endif
    localparam int BYTE_CYC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_cs_n = 1'b1;
    logic       spi_busy = 1'b0;
    logic [7:0] spi_in_byte = 8'h00;
    logic [7:0] spi_out_byte;

    spi_cmd_decoder_if #(.ADDR_W(24)) mif ();

    spi_cmd_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .spi_cs_n     (spi_cs_n),
        .spi_busy     (spi_busy),
        .spi_in_byte  (spi_in_byte),
        .spi_out_byte (spi_out_byte),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    logic [7:0]  mem_store [logic [23:0]];
    logic [7:0]  seed;
    logic [23:0] rd_a [$];
    logic [23:0] wr_a [$];
    logic [7:0]  wr_d [$];
    bit          ack_hold = 1'b0;
    bit          manual   = 1'b0;
    int          lat_min  = 1;
    int          lat_max  = 3;

    logic [7:0] tx [16];
    logic [7:0] rx [16];
    logic [7:0] wd [8];
    int         tx_n;

    function automatic logic [7:0] mem_read(input logic [23:0] a);
        logic [31:0] h;
        if (mem_store.exists(a)) return mem_store[a];
        h = {8'h00, a} * 32'h9E3779B1;
        return h[23:16] ^ seed;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Memory responder and bus protocol monitor, sampled on the falling edge.
    initial begin : responder
        int  lat;
        int  target;
        bit  sent;
        bit  prev_req, prev_ack, prev_rst, prev_we;
        logic [23:0] prev_addr;
        lat = 0; target = 1;
        prev_req = 0; prev_ack = 0; prev_rst = 0; prev_we = 0; prev_addr = '0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (manual) begin
                prev_req = 1'b0;
            end else begin
                if (mif.mem_re && mif.mem_we) viol++;
                if (prev_req && !prev_ack && !prev_rst) begin
                    if (!(mif.mem_re || mif.mem_we) || mif.mem_addr != prev_addr || mif.mem_we != prev_we)
                        viol++;
                end
                mif.mem_ack = 1'b0;
                mif.mem_rdata = 8'($urandom);
                sent = 1'b0;
                if (rst) begin
                    lat = 0;
                end else if ((mif.mem_re || mif.mem_we) && !ack_hold) begin
                    lat++;
                    if (lat >= target) begin
                        mif.mem_ack = 1'b1;
                        sent = 1'b1;
                        lat = 0;
                        target = $urandom_range(lat_max, lat_min);
                        if (mif.mem_re) begin
                            mif.mem_rdata = mem_read(mif.mem_addr);
                            rd_a.push_back(mif.mem_addr);
                        end else begin
                            wr_a.push_back(mif.mem_addr);
                            wr_d.push_back(mif.mem_wdata);
                            mem_store[mif.mem_addr] = mif.mem_wdata;
                        end
                    end
                end
                prev_req  = mif.mem_re || mif.mem_we;
                prev_ack  = sent;
                prev_rst  = rst;
                prev_we   = mif.mem_we;
                prev_addr = mif.mem_addr;
            end
        end
    end

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] got);
        spi_in_byte = b;
        spi_busy = 1'b1;
        repeat (BYTE_CYC) @(posedge clk);
        #1 spi_busy = 1'b0;
        @(posedge clk);
        #1 got = spi_out_byte;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mif.mem_re || mif.mem_we) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("bus_idle_timeout", {31'b0, mif.mem_re | mif.mem_we}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit wait_done);
        rd_a.delete(); wr_a.delete(); wr_d.delete();
        @(posedge clk);
        #1 spi_cs_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tx_n; i++) spi_byte(tx[i], rx[i]);
        repeat (2) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        if (wait_done) wait_idle();
        else begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic read_frame(input logic [23:0] a, input int n, input string tag);
        logic [23:0] ea;
        tx_n = 4 + n;
        tx[0] = 8'h03; tx[1] = a[23:16]; tx[2] = a[15:8]; tx[3] = a[7:0];
        for (int k = 0; k < n; k++) tx[4+k] = 8'($urandom);
        run_frame(1'b1);
        for (int i = 0; i < 4; i++) check({tag, "_hdr_out"}, 32'(rx[i]), 32'hFF);
        ea = a;
        for (int k = 0; k < n; k++) begin
            check({tag, "_rdata"}, 32'(rx[4+k]), 32'(mem_read(ea)));
            ea = ea + STEP;
        end
        check({tag, "_nreads"}, 32'(rd_a.size()), 32'(n + 1));
        ea = a;
        for (int k = 0; k <= n; k++) begin
            if (k < rd_a.size()) check({tag, "_raddr"}, 32'(rd_a[k]), 32'(ea));
            ea = ea + STEP;
        end
    endtask

    task automatic write_frame(input logic [23:0] a, input int n, input string tag);
        logic [23:0] ea;
        tx_n = 4 + n;
        tx[0] = 8'h02; tx[1] = a[23:16]; tx[2] = a[15:8]; tx[3] = a[7:0];
        for (int k = 0; k < n; k++) tx[4+k] = wd[k];
        run_frame(1'b1);
        check({tag, "_out"}, 32'(rx[tx_n-1]), 32'hFF);
        check({tag, "_nwrites"}, 32'(wr_a.size()), 32'(n));
        ea = a;
        for (int k = 0; k < n; k++) begin
            if (k < wr_a.size()) begin
                check({tag, "_waddr"}, 32'(wr_a[k]), 32'(ea));
                check({tag, "_wdata"}, 32'(wr_d[k]), 32'(wd[k]));
            end
            ea = ea + STEP;
        end
    endtask

    task automatic status_frame(input logic [7:0] exp, input bit wait_done, input string tag);
        tx_n = 2; tx[0] = 8'h05; tx[1] = 8'h00;
        run_frame(wait_done);
        check({tag, "_status"}, 32'(rx[0]), 32'(exp));
        check({tag, "_after"}, 32'(rx[1]), 32'hFF);
    endtask

    initial begin : main
        logic [23:0] a;
        logic [7:0]  dummy;
        int          n;
        seed = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(spi_out_byte), 32'hFF);
        check("rst_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_wdata", 32'(mif.mem_wdata), 32'd0);
        check("rst_we", 32'(mif.mem_we), 32'd0);
        check("rst_re", 32'(mif.mem_re), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Read burst with fixed two-cycle memory latency.
        lat_min = 2; lat_max = 2;
        mem_store[24'h123456] = 8'hAB;
        mem_store[24'h123457] = 8'hCD;
        read_frame(24'h123456, 2, "burst");
        status_frame(8'h00, 1'b1, "burst");
        lat_min = 1; lat_max = 3;

        wd[0] = 8'h11; wd[1] = 8'h22;
        write_frame(24'h7E0010, 2, "write");

        read_frame(24'hFFFFFF, 2, "wrap");

        for (int it = 0; it < 6; it++) begin
            a = 24'($urandom);
            n = $urandom_range(4, 1);
            read_frame(a, n, "rnd_rd");
            for (int k = 0; k < n; k++) wd[k] = 8'($urandom);
            write_frame(a, n, "rnd_wr");
            read_frame(a, n, "rnd_rb");
        end

        // Read overrun: the prefetch never arrives before the data byte.
        ack_hold = 1'b1;
        tx_n = 5; tx[0] = 8'h03; tx[1] = 8'h40; tx[2] = 8'h00; tx[3] = 8'h00; tx[4] = 8'h00;
        run_frame(1'b0);
        check("ovr_rd_out", 32'(rx[4]), 32'hFF);
        status_frame(8'h03, 1'b0, "ovr_pend");
        ack_hold = 1'b0;
        wait_idle();
        check("ovr_nreads", 32'(rd_a.size()), 32'd1);
        if (rd_a.size() > 0) check("ovr_raddr", 32'(rd_a[0]), 32'h400000);
        status_frame(8'h00, 1'b1, "ovr_clr");

        // Write overrun: second data byte arrives while the first write is pending.
        ack_hold = 1'b1;
        tx_n = 6; tx[0] = 8'h02; tx[1] = 8'h50; tx[2] = 8'h00; tx[3] = 8'h00; tx[4] = 8'h11; tx[5] = 8'h22;
        run_frame(1'b0);
        ack_hold = 1'b0;
        wait_idle();
        check("wovr_nwrites", 32'(wr_a.size()), 32'd1);
        if (wr_a.size() > 0) begin
            check("wovr_waddr", 32'(wr_a[0]), 32'h500000);
            check("wovr_wdata", 32'(wr_d[0]), 32'h11);
        end
        status_frame(8'h02, 1'b1, "wovr");
        status_frame(8'h00, 1'b1, "wovr_clr");

        // Unknown opcode: dropped frame, no memory traffic.
        tx_n = 3; tx[0] = 8'h9F; tx[1] = 8'h00; tx[2] = 8'h00;
        run_frame(1'b1);
        for (int i = 0; i < 3; i++) check("drop_out", 32'(rx[i]), 32'hFF);
        check("drop_nreq", 32'(rd_a.size() + wr_a.size()), 32'd0);

        // Acknowledge in the same cycle as the data byte completes.
        manual = 1'b1;
        mif.mem_ack = 1'b0;
        @(posedge clk);
        #1 spi_cs_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        spi_byte(8'h03, dummy); spi_byte(8'h00, dummy); spi_byte(8'h20, dummy); spi_byte(8'h00, dummy);
        check("coll_re_issued", 32'(mif.mem_re), 32'd1);
        check("coll_addr0", 32'(mif.mem_addr), 32'h002000);
        spi_in_byte = 8'hA5;
        spi_busy = 1'b1;
        repeat (BYTE_CYC) @(posedge clk);
        #1 spi_busy = 1'b0;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 8'h5C;
        @(posedge clk);
        #1 mif.mem_ack = 1'b0;
        mif.mem_rdata = 8'h00;
        check("coll_out", 32'(spi_out_byte), 32'h5C);
        check("coll_re_next", 32'(mif.mem_re), 32'd1);
        check("coll_addr1", 32'(mif.mem_addr), 32'(24'h002000 + STEP));
        mif.mem_ack = 1'b1;
        @(posedge clk);
        #1 mif.mem_ack = 1'b0;
        spi_cs_n = 1'b1;
        check("coll_retired", 32'(mif.mem_re), 32'd0);
        manual = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        status_frame(8'h00, 1'b1, "coll");

        // Reset while a read is outstanding.
        ack_hold = 1'b1;
        @(posedge clk);
        #1 spi_cs_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        spi_byte(8'h03, dummy); spi_byte(8'h00, dummy); spi_byte(8'h00, dummy); spi_byte(8'h30, dummy);
        check("mid_re_high", 32'(mif.mem_re), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_re", 32'(mif.mem_re), 32'd0);
        check("mid_rst_out", 32'(spi_out_byte), 32'hFF);
        check("mid_rst_addr", 32'(mif.mem_addr), 32'd0);
        rst = 1'b0;
        spi_cs_n = 1'b1;
        ack_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        status_frame(8'h00, 1'b1, "post_rst");

        check("bus_protocol", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command/transaction layer directly downstream of the byte-level SPI slave. Watches the slave's `busy` handshake to detect each completed byte, parses frames of opcode + 24-bit address + data, and turns them into single-byte read/write requests on the cartridge-side memory bus. It also drives the slave's `out_byte` with read data and status, so the host sees the results in the following SPI byte.

## Interface
- `ADDR_W`, 24: memory address width (SNES 24-bit bus).
- `IDLE_BYTE`, 8'hFF: value driven on `spi_out_byte` when there is nothing to return.
- `clk` in 1: system clock; the same clock as the SPI slave.
- `rst` in 1: reset, synchronous and active-high.
- `spi_cs_n` in 1: frame select, already synchronized to `clk`. Low = frame active.
- `spi_busy` in 1: slave `busy`. A 1→0 transition means a byte is complete.
- `spi_in_byte` in 8: slave `in_byte`. Valid when the byte completes.
- `spi_out_byte` out 8: feeds slave `out_byte`.
- `mem_addr` out ADDR_W: request address.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: write request, held until acknowledged.
- `mem_re` out 1: read request, held until acknowledged.
- `mem_rdata` in 8: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: single-cycle acknowledge of the pending request.

## Operation
- Byte detection:
  - `busy_d` is `spi_busy` registered.
  - `byte_done = busy_d & ~spi_busy`, evaluated in the current cycle.
  - `spi_in_byte` is sampled in the `byte_done` cycle.
- FSM states: IDLE, CMD, A2, A1, A0, RD, WR, STAT, DROP.
- IDLE→CMD when `spi_cs_n` is low.
- `byte_done` in CMD, decoded by opcode:
  - 0x03 (read) → A2.
  - 0x02 (write) → A2.
  - 0x05 (status) → STAT.
  - Any other opcode → DROP.
- Address phase: A2, A1, A0 load `addr[23:16]`, `addr[15:8]`, `addr[7:0]` in that order.
- Leaving A0:
  - Read frame → RD, and a read of `addr` is issued.
  - Write frame → WR.
- RD:
  - On `mem_ack`, `mem_rdata` is latched into the prefetch register and `pf_valid` is set.
  - On `byte_done`, `spi_out_byte` ← prefetch, `pf_valid` is cleared, `addr` advances, and the next read is issued.
- WR: each `byte_done` issues a write of `spi_in_byte` to `addr`; on `mem_ack`, `addr` advances.
- STAT: on entry, `spi_out_byte` ← `{6'b0, ovr, req_pending}`. `ovr` clears when that status byte completes.
- DROP: ignores all bytes until the end of the frame.
- `spi_cs_n` high in any state → IDLE next cycle; `spi_out_byte` ← IDLE_BYTE.
- Overrun (`ovr`, sticky):
  - RD: `byte_done` while `pf_valid` = 0. Drive IDLE_BYTE, set `ovr`, do not issue a new read.
  - WR: `byte_done` while a write is pending. The byte is dropped and `ovr` is set.
- Address arithmetic is modulo 2^ADDR_W: 24'hFFFFFF + 1 = 24'h000000.
- Only one request is outstanding at a time. `mem_we` and `mem_re` are never high together.

## Timing
- Reset values:
  - `spi_out_byte` = IDLE_BYTE.
  - `mem_addr` = 0, `mem_wdata` = 0.
  - `mem_we` = 0, `mem_re` = 0.
  - FSM = IDLE; `ovr`, `pf_valid`, `busy_d` = 0.
- A reset mid-request drops `mem_re`/`mem_we` in the next cycle, with no acknowledge wait.
- Request latency: `mem_re`/`mem_we` rise in the cycle after the triggering `byte_done` (A0 for the first read, WR data bytes) and stay high through the `mem_ack` cycle. They are low in the cycle after `mem_ack`.
- `spi_out_byte` updates in the cycle after `byte_done`. It must be stable before the next SPI rising edge; the SPI clock period budget therefore covers read latency + 2 `clk`.
- A frame end during a pending request: the request is held until `mem_ack`, and no further requests are issued.
- `mem_ack` and `byte_done` in the same cycle: the ack is applied first, so the prefetch is used and no overrun is flagged.

## Configuration
- `SPI_CMD_AUTOINC_EN` defined: `addr` increments after every RD/WR byte (burst mode).
- `SPI_CMD_AUTOINC_EN` undefined: `addr` stays fixed for the whole frame, giving port/FIFO-style access. All other behaviour is unchanged.

## Test plan
- Read burst, memory ack after 2 cycles: frame 03 12 34 56 00 00, memory returns 0xAB then 0xCD. Required: reads at 0x123456, 0x123457; host receives AB, CD; `ovr` = 0.
- Write: frame 02 7E 00 10 11 22. Required: writes (0x7E0010, 0x11) and (0x7E0011, 0x22); each `mem_we` is held until `mem_ack`.
- Wrap: read at FF FF FF with two data bytes. Required: second address is 0x000000. With `SPI_CMD_AUTOINC_EN` undefined, both reads are at 0xFFFFFF.
- Overrun, then status: read with `mem_ack` withheld across one data byte. Required: host gets FF and `ovr` is set. Then frame 05 00 returns 0x02 (or 0x03 if the stuck request is still pending), and a repeated status frame returns 0x00 once the request has completed.
- Abort/unknown: frame 9F 00 00 returns all FF with no memory request. Reset asserted while `mem_re` is high clears `mem_re` the next cycle and returns the FSM to IDLE.
